// File: rtl/bcd_pkg.sv
// Shared types and helpers for the streaming BCD modulus checker.
// Holds the FSM state encoding, BCD digit constants and the legality test.
package bcd_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam int BCD_W   = 4;
    localparam int BCD_MAX = 9;

    function automatic logic is_bcd(input logic [BCD_W-1:0] digit);
        return digit <= BCD_W'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_mod_stream_checker_if.sv
// Digit-in / result-out handshake bundle for bcd_mod_stream_checker.
// The master side is the digit source plus result consumer; the slave side is the checker.
interface bcd_mod_stream_checker_if
    import bcd_pkg::*;
#(
    parameter int MAX_DIGITS = 4,
    parameter int MODULUS    = 3
);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int REM_W = $clog2(MODULUS);

    logic             in_valid;
    logic             in_ready;
    logic [BCD_W-1:0] in_digit;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic             divisible;
    logic [REM_W-1:0] remainder;
    logic [CNT_W-1:0] digit_cnt;
    logic             bcd_err;

    modport master (
        output in_valid, in_digit, in_last, out_ready,
        input  in_ready, out_valid, divisible, remainder, digit_cnt, bcd_err
    );

    modport slave (
        input  in_valid, in_digit, in_last, out_ready,
        output in_ready, out_valid, divisible, remainder, digit_cnt, bcd_err
    );
endinterface

// File: rtl/bcd_mod_step.sv
// One Horner step of the decimal remainder: rem_out = (rem_in*10 + digit) mod MODULUS.
// Illegal digits contribute 0 so the remainder stays defined; the error is tracked upstream.
module bcd_mod_step
    import bcd_pkg::*;
#(
    parameter  int MODULUS = 3,
    localparam int REM_W   = $clog2(MODULUS)
) (
    input  logic [REM_W-1:0] rem_in_i,
    input  logic [BCD_W-1:0] digit_i,
    output logic [REM_W-1:0] rem_out_o
);
    // Wide enough for the worst case 10*(MODULUS-1)+9 = 10*MODULUS-1.
    localparam int SUM_W = $clog2(10 * MODULUS);

    logic [BCD_W-1:0] digit_eff;
    logic [SUM_W-1:0] acc;

    assign digit_eff = is_bcd(digit_i) ? digit_i : '0;
    assign acc       = SUM_W'(rem_in_i) * SUM_W'(10) + SUM_W'(digit_eff);
    assign rem_out_o = REM_W'(acc % SUM_W'(MODULUS));
endmodule

// File: rtl/bcd_mod_stream_checker.sv
// Streams BCD digits MSD-first, keeps a running remainder modulo MODULUS and presents a
// registered, held-until-accepted result when the frame closes (in_last or MAX_DIGITS reached).
module bcd_mod_stream_checker
    import bcd_pkg::*;
#(
    parameter int MAX_DIGITS = 4,
    parameter int MODULUS    = 3
) (
    input logic                     clk,
    input logic                     rst,
    bcd_mod_stream_checker_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int REM_W = $clog2(MODULUS);

    state_t           state_q;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic             out_valid_q;
    logic             divisible_q;
    logic [REM_W-1:0] remainder_q;
    logic [CNT_W-1:0] digit_cnt_q;
    logic             bcd_err_q;

    logic             accept;
    logic             close;

    bcd_mod_step #(.MODULUS(MODULUS)) u_step (
        .rem_in_i  (rem_q),
        .digit_i   (bus.in_digit),
        .rem_out_o (rem_d)
    );

    // in_ready depends on state only, so out_ready never reaches it combinationally.
    assign accept = bus.in_valid && (state_q == ACCUM);
    assign cnt_d  = cnt_q + CNT_W'(1);
    assign err_d  = err_q | ~is_bcd(bus.in_digit);
    assign close  = accept && (bus.in_last || (cnt_q == CNT_W'(MAX_DIGITS - 1)));

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            rem_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            divisible_q <= 1'b0;
            remainder_q <= '0;
            digit_cnt_q <= '0;
            bcd_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (accept) begin
                        rem_q <= rem_d;
                        cnt_q <= cnt_d;
                        err_q <= err_d;
                    end
                    if (close) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        divisible_q <= (rem_d == '0) && !err_d;
                        remainder_q <= rem_d;
                        digit_cnt_q <= cnt_d;
                        bcd_err_q   <= err_d;
                    end
                end
                DONE: begin
                    // Result registers are left untouched so they stay readable after out_valid falls.
                    if (bus.out_ready) begin
                        state_q     <= ACCUM;
                        out_valid_q <= 1'b0;
                        rem_q       <= '0;
                        cnt_q       <= '0;
                        err_q       <= 1'b0;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = out_valid_q;
    assign bus.divisible = divisible_q;
    assign bus.remainder = remainder_q;
    assign bus.digit_cnt = digit_cnt_q;
    assign bus.bcd_err   = bcd_err_q;
endmodule
